// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM for a multicycle ARM-subset datapath.
// Optional CMP_NOWRITE_EN: CMP (Funct[4:1]=1010) updates flags without writing Rd.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t      state, state_next;
  logic [3:0]  flags;
  logic        cond_ex;
  logic        cond_met;
  logic [1:0]  alu_ctl;
  logic [1:0]  flag_w;
  logic        no_write;
  logic        executing;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        unused_bits;

  assign cond        = Instr[19:16];
  assign op          = Instr[15:14];
  assign funct       = Instr[13:8];
  assign unused_bits = ^Instr[7:0];
  assign State       = state;
  assign executing   = (state == S_EXECUTER) || (state == S_EXECUTEI);

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags;
    cond_met = 1'b0;
    case (cond)
      4'h0: cond_met = z;
      4'h1: cond_met = ~z;
      4'h2: cond_met = c;
      4'h3: cond_met = ~c;
      4'h4: cond_met = n;
      4'h5: cond_met = ~n;
      4'h6: cond_met = v;
      4'h7: cond_met = ~v;
      4'h8: cond_met = c & ~z;
      4'h9: cond_met = ~c | z;
      4'hA: cond_met = (n == v);
      4'hB: cond_met = (n != v);
      4'hC: cond_met = ~z & (n == v);
      4'hD: cond_met = z | (n != v);
      4'hE: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  // Arithmetic ops may update all of NZCV; logical ops only touch NZ.
  always_comb begin
    alu_ctl  = 2'b00;
    flag_w   = 2'b00;
    no_write = 1'b0;
    case (funct[4:1])
      4'b0100: begin alu_ctl = 2'b00; flag_w = {funct[0], funct[0]}; end
      4'b0010: begin alu_ctl = 2'b01; flag_w = {funct[0], funct[0]}; end
      4'b0000: begin alu_ctl = 2'b10; flag_w = {funct[0], 1'b0};     end
      4'b1100: begin alu_ctl = 2'b11; flag_w = {funct[0], 1'b0};     end
      4'b1010: begin
        alu_ctl = 2'b01;
        flag_w  = {funct[0], funct[0]};
`ifdef CMP_NOWRITE_EN
        no_write = 1'b1;
`else
        no_write = 1'b0;
`endif
      end
      default: begin alu_ctl = 2'b00; flag_w = 2'b00; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      flags   <= 4'b0000;
      cond_ex <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) cond_ex <= cond_met;
      if (executing && cond_ex) begin
        if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
        if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    state_next = S_FETCH;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    ImmSrc     = op;
    RegSrc     = {op == 2'b01, op == 2'b10};
    case (state)
      S_FETCH: begin
        state_next = S_DECODE;
        IRWrite = 1'b1; PCWrite = 1'b1; ALUSrcA = 1'b1;
        ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_DECODE: begin
        case (op)
          2'b00:   state_next = funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_next = S_MEMADR;
          2'b10:   state_next = S_BRANCH;
          default: state_next = S_FETCH;
        endcase
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        state_next = funct[0] ? S_MEMREAD : S_MEMWRITE;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        state_next = S_MEMWB;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01; RegWrite = cond_ex;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1; MemWrite = cond_ex;
      end
      S_EXECUTER: begin
        state_next = S_ALUWB;
        ALUControl = alu_ctl;
      end
      S_EXECUTEI: begin
        state_next = S_ALUWB;
        ALUSrcB = 2'b01; ALUControl = alu_ctl;
      end
      S_ALUWB: RegWrite = cond_ex & ~no_write;
      S_BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = cond_ex;
      end
      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl.
// Honours CMP_NOWRITE_EN when it is defined for the build.
module tb_multicycle_ctrl;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWRITE = 4'd5, EXR = 4'd6, EXI = 4'd7,
                         ALUWB = 4'd8, BRANCH = 4'd9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = 20'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0]  State;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .State(State)
  );

  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  logic [19:0] sb_q[$];
  logic [3:0]  mflags = 4'h0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;        4'h1: return !z;
      4'h2: return cy;       4'h3: return !cy;
      4'h4: return n;        4'h5: return !n;
      4'h6: return v;        4'h7: return !v;
      4'h8: return cy && !z; 4'h9: return !cy || z;
      4'hA: return n == v;   4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 2'd0;  // ADD
      4'b0010: return 2'd1;  // SUB
      4'b0000: return 2'd2;  // AND
      4'b1100: return 2'd3;  // ORR
      4'b1010: return 2'd1;  // CMP
      default: return 2'd0;
    endcase
  endfunction

  // Expected output word: {State, PCW, MW, RW, IRW, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl}
  function automatic logic [19:0] exp_vec(input logic [3:0] st, input logic [1:0] op,
                                          input logic [5:0] funct, input bit cx, input bit nw);
    logic pcw, mw, rw, irw, adr, asa;
    logic [1:0] asb, rs, ac;
    {pcw, mw, rw, irw, adr, asa} = 6'b0;
    asb = 2'd0; rs = 2'd0; ac = 2'd0;
    case (st)
      FETCH:    begin irw = 1; pcw = 1; asa = 1; asb = 2'd2; rs = 2'd2; end
      DECODE:   begin asa = 1; asb = 2'd2; rs = 2'd2; end
      MEMADR:   asb = 2'd1;
      MEMREAD:  adr = 1;
      MEMWB:    begin rs = 2'd1; rw = cx; end
      MEMWRITE: begin adr = 1; mw = cx; end
      EXR:      ac = alu_of(funct[4:1]);
      EXI:      begin asb = 2'd1; ac = alu_of(funct[4:1]); end
      ALUWB:    rw = cx && !nw;
      BRANCH:   begin asb = 2'd1; rs = 2'd2; pcw = cx; end
      default:  ;
    endcase
    return {st, pcw, mw, rw, irw, adr, asa, asb, rs, op, op == 2'd1, op == 2'd2, ac};
  endfunction

  // Queue the expected trace for one instruction starting at FETCH; optionally reset in MEMADR.
  task automatic issue(input logic [19:0] ins, input logic [3:0] af, input bit rst_in_memadr);
    logic [3:0] cond, cmd;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] seq[$];
    bit cx, nw;
    cond = ins[19:16]; op = ins[15:14]; funct = ins[13:8]; cmd = funct[4:1];
    cx = cond_ok(cond, mflags);
`ifdef CMP_NOWRITE_EN
    nw = (cmd == 4'b1010);
`else
    nw = 1'b0;
`endif
    seq.push_back(FETCH);
    seq.push_back(DECODE);
    case (op)
      2'd0: begin seq.push_back(funct[5] ? EXI : EXR); seq.push_back(ALUWB); end
      2'd1: begin
        seq.push_back(MEMADR);
        if (!rst_in_memadr) begin
          if (funct[0]) begin seq.push_back(MEMREAD); seq.push_back(MEMWB); end
          else seq.push_back(MEMWRITE);
        end
      end
      2'd2: seq.push_back(BRANCH);
      default: ;
    endcase
    Instr = ins;
    ALUFlags = af;
    foreach (seq[i]) sb_q.push_back(exp_vec(seq[i], op, funct, cx, nw));
    if (op == 2'd0 && cx && funct[0]) begin
      if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010) mflags = af;
      else if (cmd == 4'b0000 || cmd == 4'b1100) mflags[3:2] = af[3:2];
    end
    if (rst_in_memadr) begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      mflags = 4'h0;
    end else begin
      repeat (seq.size()) @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [19:0] got, exp;
    if (mon_en) begin
      got = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
             ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow got=%05h", got);
      end else begin
        exp = sb_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL sb_cycle t=%0t got=%05h exp=%05h", $time, got, exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] cmds[5];
    logic [19:0] ins;
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100; cmds[4] = 4'b1010;

    Instr = 20'hE5910;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", State, 0);
    check("rst_irwrite", IRWrite, 1);
    check("rst_pcwrite", PCWrite, 1);
    check("rst_memwrite", MemWrite, 0);
    check("rst_regwrite", RegWrite, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    issue(20'h0A000, 4'h0, 0);   // BEQ right after reset: flags clear, not taken
    issue(20'hE0821, 4'hF, 0);   // ADD R1,R2,R3
    issue(20'hE5910, 4'h0, 0);   // LDR
    issue(20'hE0521, 4'h4, 0);   // SUBS -> Z set
    issue(20'h0A000, 4'h0, 0);   // BEQ taken
    issue(20'h1A000, 4'h0, 0);   // BNE not taken
    issue(20'hE1520, 4'h9, 0);   // CMP
    issue(20'h9A000, 4'h0, 0);   // BLS observes CMP flags
    issue(20'hF5800, 4'h0, 0);   // STR never-condition
    issue(20'hE5800, 4'h0, 1);   // STR abandoned by reset in MEMADR
    issue(20'h0A000, 4'h0, 0);   // flags cleared by reset

    for (int k = 0; k < 300; k++) begin
      ins = $urandom;
      if ($urandom_range(0, 1) == 0) ins[12:9] = cmds[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) ins[19:16] = 4'hE;
      issue(ins, 4'($urandom), (ins[15:14] == 2'd1) && ($urandom_range(0, 19) == 0));
    end

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    mon_en = 1'b0;
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
